led_anim_engine: RTL

Parametrised LED animation engine that drives `N_LEDS` outputs with one of eight selectable patterns, advanced at a programmable step rate and dimmed by a global PWM brightness control. It is the next-generation replacement for the fixed 8-LED, 4-mode animation top. It sits between the board-level mode/brightness controls and the LED pins.

---
 rtl/led_anim_pkg.sv | 27 ++
 rtl/led_tick_gen.sv | 27 ++
 rtl/led_anim_engine.sv | 121 ++++++++++++
 3 files changed

// File: rtl/led_anim_pkg.sv
// Shared encodings for the LED animation engine and the board controller that drives it.
// Mode values are the 3-bit codes presented on the engine's mode input.
package led_anim_pkg;

  typedef enum logic [2:0] {
    MODE_OFF      = 3'd0,
    MODE_ON       = 3'd1,
    MODE_SHL      = 3'd2,
    MODE_SHR      = 3'd3,
    MODE_PINGPONG = 3'd4,
    MODE_COUNT    = 3'd5,
    MODE_BAR      = 3'd6,
    MODE_BLINK    = 3'd7
  } anim_mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } pp_dir_e;

  // Observable pattern-FSM state: latched mode and the ping-pong sweep direction.
  typedef struct packed {
    anim_mode_e mode_q;
    pp_dir_e    dir;
  } anim_dbg_t;

endpackage

// File: rtl/led_tick_gen.sv
// Animation step timer: produces a single-cycle tick once every TICK_DIV enabled cycles.
// While en is low the count is held exactly, so no tick is gained or lost.
module led_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] tcnt;

  assign tick = en && (tcnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (en) begin
      tcnt <= tick ? '0 : tcnt + W'(1);
    end
  end

endmodule

// File: rtl/led_anim_engine.sv
// LED animation engine: eight pattern modes stepped by led_tick_gen, dimmed by a global PWM.
// A mode request is latched only on a tick; that tick loads the mode's initial pattern.
module led_anim_engine
  import led_anim_pkg::*;
#(
  parameter int N_LEDS   = 8,
  parameter int TICK_DIV = 50000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LEDS-1:0]   led_out,
  output logic                step,
  output anim_dbg_t           dbg
);

  logic                tick;
  logic [N_LEDS-1:0]   pat_q, pat_d;
  anim_mode_e          mode_q, mode_d;
  pp_dir_e             dir_q, dir_d;
  logic [PWM_BITS-1:0] pcnt;
  logic                lit;
  anim_mode_e          mode_req;

  assign mode_req = anim_mode_e'(mode);

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  function automatic logic [N_LEDS-1:0] init_pat(input anim_mode_e m);
    logic [N_LEDS-1:0] p;
    p = '0;
    case (m)
      MODE_ON, MODE_BLINK:     p = '1;
      MODE_SHL, MODE_PINGPONG: p = N_LEDS'(1);
      MODE_SHR:                p = {1'b1, {(N_LEDS-1){1'b0}}};
      default:                 p = '0;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= '0;
      mode_q <= MODE_OFF;
      dir_q  <= DIR_LEFT;
    end else begin
      pat_q  <= pat_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
    end
  end

  always_comb begin
    pat_d  = pat_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    if (tick) begin
      if (mode_req != mode_q) begin
        mode_d = mode_req;
        pat_d  = init_pat(mode_req);
        dir_d  = DIR_LEFT;
      end else begin
        case (mode_q)
          MODE_SHL:   pat_d = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
          MODE_SHR:   pat_d = {pat_q[0], pat_q[N_LEDS-1:1]};
          // Reverse on reaching an end so the end LED is shown for only one step.
          MODE_PINGPONG: begin
            if (dir_q == DIR_LEFT) begin
              if (pat_q[N_LEDS-1]) begin
                pat_d = pat_q >> 1;
                dir_d = DIR_RIGHT;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                pat_d = pat_q << 1;
                dir_d = DIR_LEFT;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          MODE_COUNT: pat_d = pat_q + N_LEDS'(1);
          MODE_BAR:   pat_d = (&pat_q) ? '0 : {pat_q[N_LEDS-2:0], 1'b1};
          MODE_BLINK: pat_d = ~pat_q;
          default:    pat_d = pat_q;
        endcase
      end
    end
  end

  // All-ones brightness must be fully on, which pcnt < brightness alone cannot reach.
  assign lit = (&brightness) || (pcnt < brightness);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt    <= '0;
      step    <= 1'b0;
      led_out <= '0;
    end else begin
      pcnt    <= pcnt + PWM_BITS'(1);
      step    <= tick;
      led_out <= lit ? pat_q : '0;
    end
  end

  assign dbg.mode_q = mode_q;
  assign dbg.dir    = dir_q;

endmodule
